exu_ctrl: RTL and testbench

EXU_CTRL -- requirements
Module: exu_ctrl

---
 rtl/exu_ctrl_pkg.sv | 12 +
 rtl/exu_ctrl_tmo.sv | 22 ++
 rtl/exu_ctrl.sv | 125 ++++++++++++
 tb/tb_exu_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exu_ctrl_pkg.sv
// Shared constants and FSM encoding for the execute-stage memory/writeback controller.
package exu_ctrl_pkg;
  localparam int DEF_DATA_LEN       = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    WB       = 2'd3
  } state_e;
endpackage

// File: rtl/exu_ctrl_tmo.sv
// Memory-wait watchdog: counts cycles while run is high, flags expiry on the last allowed cycle.
module exu_ctrl_tmo #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (!run)     cnt <= '0;
    else if (!expired) cnt <= cnt + 1'b1;
  end

  // Expiry lands on wait cycle number TIMEOUT_CYCLES, so WB follows right after it.
  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/exu_ctrl.sv
// Single-in-flight execute controller: accepts an instruction, optionally runs one memory
// transaction, then holds writeback until consumed. Optional watchdog: EXU_CTRL_TIMEOUT_EN.
module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int DATA_LEN       = DEF_DATA_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  jump_flag,
  input  logic                  unusual_flag,
  input  logic [DATA_LEN-1:0]   addr_load,
  input  logic [DATA_LEN-1:0]   store_data,
  input  logic [DATA_LEN/8-1:0] store_mask,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_LEN-1:0]   mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_LEN-1:0]   mem_req_wdata,
  output logic [DATA_LEN/8-1:0] mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_LEN-1:0]   mem_resp_data,
  output logic [DATA_LEN-1:0]   pre_data,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  flush,
  output logic                  fault
);
  localparam int MW = DATA_LEN / 8;

  state_e              state, state_nxt;
  logic [DATA_LEN-1:0] addr_q, wdata_q;
  logic [MW-1:0]       wmask_q;
  logic                store_q, jump_q;
  logic                accept, st_eff, mem_op, tmo_hit;

  assign accept = id_valid & id_ready;
  // Load wins when both load and store are flagged; a trap skips memory entirely.
  assign st_eff = is_store & ~is_load;
  assign mem_op = (is_load | is_store) & ~unusual_flag;

`ifdef EXU_CTRL_TIMEOUT_EN
  logic fault_q;

  exu_ctrl_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .run     (state == MEM_WAIT),
    .expired (tmo_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           fault_q <= 1'b0;
    else if (state == MEM_WAIT && !mem_resp_valid && tmo_hit) fault_q <= 1'b1;
    else if (state == WB && wb_ready)                  fault_q <= 1'b0;
  end

  assign fault = fault_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept)                    state_nxt = mem_op ? MEM_REQ : WB;
      MEM_REQ:  if (mem_req_ready)             state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid || tmo_hit) state_nxt = WB;
      WB:       if (wb_ready)                  state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    id_ready      = (state == IDLE);
    mem_req_valid = (state == MEM_REQ);
    mem_req_wen   = (state == MEM_REQ) & store_q;
    wb_valid      = (state == WB);
    flush         = (state == WB) & wb_ready & jump_q;
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      store_q  <= 1'b0;
      jump_q   <= 1'b0;
      pre_data <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_load;
        wdata_q <= st_eff ? store_data : '0;
        wmask_q <= st_eff ? store_mask : '0;
        store_q <= st_eff;
        jump_q  <= jump_flag | unusual_flag;
      end
      if (state == MEM_WAIT) begin
        if (mem_resp_valid) begin
          if (!store_q) pre_data <= mem_resp_data;
        end else if (tmo_hit) begin
          pre_data <= '0;
          jump_q   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_exu_ctrl.sv
// Directed, table-driven bench for exu_ctrl plus hand sequences for reset and long waits.
module tb_exu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_ready;
  logic        is_load = 1'b0, is_store = 1'b0, jump_flag = 1'b0, unusual_flag = 1'b0;
  logic [31:0] addr_load = '0, store_data = '0;
  logic [3:0]  store_mask = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic [31:0] pre_data;
  logic        wb_valid, wb_ready = 1'b0, flush, fault;

  int total = 0;
  int bad   = 0;

  exu_ctrl #(.DATA_LEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .is_load(is_load), .is_store(is_store), .jump_flag(jump_flag), .unusual_flag(unusual_flag),
    .addr_load(addr_load), .store_data(store_data), .store_mask(store_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .pre_data(pre_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .flush(flush), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, jmp, unu;
    logic [31:0] addr, data;
    logic [3:0]  mask;
    logic        mem;
    int          req_dly, resp_dly, wb_dly;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_pre;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_id();
    id_valid = 0; is_load = 0; is_store = 0; jump_flag = 0; unusual_flag = 0;
  endtask

  task automatic run_vec(input vec_t v);
    chk("idle id_ready", 32'(id_ready), 1);
    id_valid = 1; is_load = v.ld; is_store = v.st; jump_flag = v.jmp; unusual_flag = v.unu;
    addr_load = v.addr; store_data = v.data; store_mask = v.mask;
    step();
    // scramble inputs so the outputs must come from the latches
    clear_id();
    addr_load = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF; store_mask = 4'hF;
    chk("busy id_ready", 32'(id_ready), 0);
    if (v.mem) begin
      for (int i = 0; i <= v.req_dly; i++) begin
        if (i == v.req_dly) mem_req_ready = 1;
        #1;
        chk("req_valid", 32'(mem_req_valid), 1);
        chk("req_addr", mem_req_addr, v.addr);
        chk("req_wen", 32'(mem_req_wen), 32'(v.exp_wen));
        chk("req_wdata", mem_req_wdata, v.exp_wdata);
        chk("req_wmask", 32'(mem_req_wmask), 32'(v.exp_wmask));
        step();
      end
      mem_req_ready = 0;
      chk("req_valid drop", 32'(mem_req_valid), 0);
      for (int i = 0; i <= v.resp_dly; i++) begin
        if (i == v.resp_dly) begin mem_resp_valid = 1; mem_resp_data = v.rdata; end
        chk("wait wb_valid", 32'(wb_valid), 0);
        step();
      end
      mem_resp_valid = 0; mem_resp_data = '0;
    end
    for (int i = 0; i <= v.wb_dly; i++) begin
      if (i == v.wb_dly) wb_ready = 1;
      #1;
      chk("wb_valid", 32'(wb_valid), 1);
      chk("flush", 32'(flush), (i == v.wb_dly) ? 32'(v.exp_flush) : 32'd0);
      chk("pre_data", pre_data, v.exp_pre);
      chk("fault", 32'(fault), 0);
      step();
    end
    wb_ready = 0;
    #1;
    chk("post wb_valid", 32'(wb_valid), 0);
    chk("post flush", 32'(flush), 0);
    chk("post id_ready", 32'(id_ready), 1);
  endtask

  task automatic issue_load(input logic [31:0] a);
    id_valid = 1; is_load = 1; addr_load = a;
    step();
    clear_id();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
  endtask

  initial begin
    //            ld st jmp unu addr          data          mask mem req resp wb rdata         wen wdata         wmask exp_pre       flush
    vecs[0] = '{0, 0, 0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         4'h0, 32'h0,         0};
    vecs[1] = '{1, 0, 0, 0, 32'h8000_0010, 32'hAAAA_5555, 4'hF, 1, 3, 2, 0, 32'hDEAD_BEEF, 0, 32'h0,         4'h0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{0, 1, 0, 0, 32'h8000_0020, 32'h1234_5678, 4'hF, 1, 0, 1, 0, 32'h1111_1111, 1, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 0};
    vecs[3] = '{0, 0, 1, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 4, 32'h0,         0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1};
    vecs[4] = '{1, 1, 0, 0, 32'h8000_0040, 32'h0000_0055, 4'h3, 1, 0, 0, 0, 32'hCAFE_F00D, 0, 32'h0,         4'h0, 32'hCAFE_F00D, 0};
    vecs[5] = '{1, 0, 0, 1, 32'h8000_0050, 32'h0,         4'h0, 0, 0, 0, 1, 32'h0,         0, 32'h0,         4'h0, 32'hCAFE_F00D, 1};
    vecs[6] = '{0, 1, 1, 0, 32'h8000_0060, 32'hA5A5_0F0F, 4'h5, 1, 1, 0, 2, 32'h2222_2222, 1, 32'hA5A5_0F0F, 4'h5, 32'hCAFE_F00D, 1};

    #2;
    chk("rst req_valid", 32'(mem_req_valid), 0);
    chk("rst req_addr", mem_req_addr, 0);
    chk("rst wen", 32'(mem_req_wen), 0);
    chk("rst wdata", mem_req_wdata, 0);
    chk("rst wmask", 32'(mem_req_wmask), 0);
    chk("rst pre_data", pre_data, 0);
    chk("rst wb_valid", 32'(wb_valid), 0);
    chk("rst flush", 32'(flush), 0);
    chk("rst fault", 32'(fault), 0);
    step(); step();
    rst = 0;
    step();
    chk("rel id_ready", 32'(id_ready), 1);

    foreach (vecs[k]) run_vec(vecs[k]);

    // asynchronous reset while waiting for a load response
    issue_load(32'h8000_0070);
    chk("in wait req_valid", 32'(mem_req_valid), 0);
    chk("in wait wb_valid", 32'(wb_valid), 0);
    #2 rst = 1;
    #1;
    chk("arst req_addr", mem_req_addr, 0);
    chk("arst pre_data", pre_data, 0);
    chk("arst wb_valid", 32'(wb_valid), 0);
    chk("arst flush", 32'(flush), 0);
    chk("arst id_ready", 32'(id_ready), 1);
    step();
    rst = 0;
    mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
    step();
    mem_resp_valid = 0;
    chk("late resp wb_valid", 32'(wb_valid), 0);
    chk("late resp pre_data", pre_data, 0);
    chk("late resp id_ready", 32'(id_ready), 1);

`ifdef EXU_CTRL_TIMEOUT_EN
    issue_load(32'h8000_0080);
    for (int i = 0; i < 8; i++) begin
      chk("tmo wait wb_valid", 32'(wb_valid), 0);
      step();
    end
    chk("tmo wb_valid", 32'(wb_valid), 1);
    chk("tmo fault", 32'(fault), 1);
    chk("tmo pre_data", pre_data, 0);
    wb_ready = 1;
    #1;
    chk("tmo flush", 32'(flush), 1);
    step();
    wb_ready = 0;
    #1;
    chk("tmo fault clr", 32'(fault), 0);
    chk("tmo id_ready", 32'(id_ready), 1);
`else
    issue_load(32'h8000_0090);
    for (int i = 0; i < 30; i++) begin
      if (wb_valid !== 1'b0 || fault !== 1'b0) chk("long wait idle", {wb_valid, fault}, 0);
      step();
    end
    chk("long wait wb_valid", 32'(wb_valid), 0);
    mem_resp_valid = 1; mem_resp_data = 32'h0BAD_F00D;
    step();
    mem_resp_valid = 0;
    chk("long wait resp wb", 32'(wb_valid), 1);
    chk("long wait pre_data", pre_data, 32'h0BAD_F00D);
    chk("long wait fault", 32'(fault), 0);
    wb_ready = 1;
    #1;
    chk("long wait flush", 32'(flush), 0);
    step();
    wb_ready = 0;
    #1;
    chk("long wait id_ready", 32'(id_ready), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
